// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg
//   Shared definitions for the convolution-window sequencer.
//   - state_t   : 2-bit FSM encoding (IDLE, CLEAR, STREAM, DRAIN)
//   - cnt_w_for : smallest counter width W with 2**W > max_dim
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  function automatic int cnt_w_for(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

endpackage

// File: rtl/win_pos_counter.sv
// win_pos_counter
//   Raster-order row/column position counter for the pixel stream.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     i_clr       synchronous clear to (0,0)
//     i_en        advance one pixel
//     o_row/o_col current position (the pixel accepted on the next i_en)
//     o_last      current position is the last pixel of the map
//   The row wraps to 0 after the last pixel so the counters never overflow.
module win_pos_counter
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_row,
  output logic [CNT_W-1:0] o_col,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (i_clr) begin
      row_d = '0;
      col_d = '0;
    end else if (i_en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign o_row  = row_q;
  assign o_col  = col_q;
  assign o_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for the line-buffer shift chain feeding a KxK convolution window.
//   Accepts a raster pixel stream, drives the chain shift enable / clear, and
//   flags every cycle in which the chain holds a complete window together with
//   the output-map coordinates of that window.
//   Ports:
//     clk, global_rst_n   clock, asynchronous active-low reset
//     rst                 synchronous clear to IDLE
//     i_start             start one feature map (IDLE only)
//     i_valid / o_ready   upstream pixel handshake
//     i_ready             downstream consumed the current window
//     o_ce                chain shift enable (= pixel accept)
//     o_self_rst          one-cycle chain clear at the start of a map
//     o_win_valid         complete window present; o_out_row/o_out_col its position
//     o_busy              not IDLE
//     o_done              one-cycle pulse after the last window is consumed
//   Configuration macro CONV_WIN_STRIDE2_EN: when defined, only stride-2
//   window positions are flagged and coordinates are halved.
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int CNT_W = cnt_w_for((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic             clk,
  input  logic             global_rst_n,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  output logic             o_ce,
  output logic             o_self_rst,
  output logic             o_win_valid,
  output logic [CNT_W-1:0] o_out_row,
  output logic [CNT_W-1:0] o_out_col,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);

  state_t           state_q, state_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] out_row_q, out_row_d;
  logic [CNT_W-1:0] out_col_q, out_col_d;

  logic [CNT_W-1:0] row, col;
  logic [CNT_W-1:0] row_off, col_off;
  logic             last_pix;
  logic             ready;
  logic             self_rst;
  logic             done;
  logic             accept;
  logic             win_hit;

  win_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .CNT_W(CNT_W)
  ) u_pos (
    .clk   (clk),
    .rst_n (global_rst_n),
    .i_clr (rst || (state_q == ST_CLEAR)),
    .i_en  (accept),
    .o_row (row),
    .o_col (col),
    .o_last(last_pix)
  );

  // FSM next state and handshake outputs; rst forces every output low
  // in the cycle it is asserted so nothing is accepted while clearing.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    self_rst = 1'b0;
    done     = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (i_start) state_d = ST_CLEAR;
        ST_CLEAR: begin
          self_rst = 1'b1;
          state_d  = ST_STREAM;
        end
        ST_STREAM: begin
          // Never shift the chain under a window the consumer has not taken.
          ready = !(win_valid_q && !i_ready);
          if (i_valid && ready && last_pix) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!win_valid_q) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign accept = i_valid && ready;

  // Window flag: set by the accept that completes a window, otherwise held
  // until the consumer takes it.
  always_comb begin
    row_off     = row - KM1;
    col_off     = col - KM1;
`ifdef CONV_WIN_STRIDE2_EN
    win_hit     = accept && (row >= KM1) && (col >= KM1) && !row_off[0] && !col_off[0];
`else
    win_hit     = accept && (row >= KM1) && (col >= KM1);
`endif
    win_valid_d = win_valid_q && !i_ready;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (win_hit) begin
      win_valid_d = 1'b1;
`ifdef CONV_WIN_STRIDE2_EN
      out_row_d   = row_off >> 1;
      out_col_d   = col_off >> 1;
`else
      out_row_d   = row_off;
      out_col_d   = col_off;
`endif
    end
    if (rst) begin
      win_valid_d = 1'b0;
      out_row_d   = '0;
      out_col_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign o_ready     = ready;
  assign o_ce        = accept;
  assign o_self_rst  = self_rst;
  assign o_win_valid = win_valid_q;
  assign o_out_row   = out_row_q;
  assign o_out_col   = out_col_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int K     = 3;
  localparam int CNT_W = 6;
  localparam int TOTAL_PIX = IMG_W * IMG_H;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int EXP_WINS = ((IMG_W - K + 2) / 2) * ((IMG_H - K + 2) / 2);
`else
  localparam int EXP_WINS = (IMG_W - K + 1) * (IMG_H - K + 1);
`endif

  logic             clk;
  logic             global_rst_n;
  logic             rst;
  logic             i_start;
  logic             i_valid;
  logic             o_ready;
  logic             i_ready;
  logic             o_ce;
  logic             o_self_rst;
  logic             o_win_valid;
  logic [CNT_W-1:0] o_out_row;
  logic [CNT_W-1:0] o_out_col;
  logic             o_busy;
  logic             o_done;

  conv_window_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .K    (K),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .global_rst_n(global_rst_n),
    .rst         (rst),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ready     (i_ready),
    .o_ce        (o_ce),
    .o_self_rst  (o_self_rst),
    .o_win_valid (o_win_valid),
    .o_out_row   (o_out_row),
    .o_out_col   (o_out_col),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rule: does accepting pixel (r,c) complete a reported window?
  function automatic bit is_win(input int r, input int c);
    if (r < K - 1 || c < K - 1) return 1'b0;
`ifdef CONV_WIN_STRIDE2_EN
    return ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int win_coord(input int p);
`ifdef CONV_WIN_STRIDE2_EN
    return (p - (K - 1)) / 2;
`else
    return p - (K - 1);
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_ce"}, o_ce, 0);
    chk({tag, "_srst"}, o_self_rst, 0);
    chk({tag, "_wv"}, o_win_valid, 0);
    chk({tag, "_row"}, o_out_row, 0);
    chk({tag, "_col"}, o_out_col, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  // One feature map. vmode/rmode: 0 always 1, 1 pattern (toggle / 5-cycle stall
  // on window (1,1)), 2 random. rst_at >= 0 pulses rst when that many pixels
  // have been accepted.
  task automatic run_map(input int vmode, input int rmode, input int rst_at, input string tag);
    int  acc, wins, hold, cyc, r, c, pr, pc;
    bit  pend, done_seen, aborted, v, rdy, rs, exp_ready, exp_ce, exp_done;
    acc = 0; wins = 0; hold = 0; cyc = 0; pr = 0; pc = 0;
    pend = 0; done_seen = 0; aborted = 0;

    @(posedge clk); #1;
    i_start = 1'b1; i_valid = 1'b0; i_ready = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, o_busy, 0);
    @(posedge clk); #1;
    i_start = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_clear_srst"}, o_self_rst, 1);
    chk({tag, "_clear_ready"}, o_ready, 0);
    chk({tag, "_clear_ce"}, o_ce, 0);

    while (!done_seen && !aborted && cyc < 2000) begin
      @(posedge clk); #1;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          rdy = 1'b1;
          if (pend && pr == 1 && pc == 1 && hold < 5) begin
            rdy = 1'b0;
            hold++;
          end
        end
        default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      rs = (rst_at >= 0) && (acc == rst_at);
      i_valid = v; i_ready = rdy; rst = rs;
      i_start = ($urandom_range(0, 7) == 0);  // must be ignored outside IDLE

      exp_ready = !rs && (acc < TOTAL_PIX) && !(pend && !rdy);
      exp_ce    = v && exp_ready;
      exp_done  = !rs && (acc == TOTAL_PIX) && !pend;

      @(negedge clk);
      chk({tag, "_ready"}, o_ready, exp_ready);
      chk({tag, "_ce"}, o_ce, exp_ce);
      chk({tag, "_wv"}, o_win_valid, pend);
      if (pend) begin
        chk({tag, "_out_row"}, o_out_row, pr);
        chk({tag, "_out_col"}, o_out_col, pc);
      end
      chk({tag, "_srst"}, o_self_rst, 0);
      chk({tag, "_busy"}, o_busy, 1);
      chk({tag, "_done"}, o_done, exp_done);

      if (rs) begin
        @(posedge clk); #1;
        rst = 1'b0; i_valid = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check_all_zero({tag, "_after_rst"});
        aborted = 1'b1;
      end else begin
        if (exp_done) done_seen = 1'b1;
        if (exp_ce) begin
          r = acc / IMG_W;
          c = acc % IMG_W;
          acc++;
          if (is_win(r, c)) begin
            pend = 1'b1; pr = win_coord(r); pc = win_coord(c); wins++;
          end else if (rdy) begin
            pend = 1'b0;
          end
        end else if (rdy) begin
          pend = 1'b0;
        end
      end
      cyc++;
    end

    if (!aborted) begin
      chk({tag, "_done_seen"}, done_seen, 1);
      chk({tag, "_win_count"}, wins, EXP_WINS);
      chk({tag, "_pix_count"}, acc, TOTAL_PIX);
      @(posedge clk); #1;
      i_valid = 1'b0; i_start = 1'b0; i_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_post_busy"}, o_busy, 0);
      chk({tag, "_post_done"}, o_done, 0);
    end
    i_valid = 1'b0; i_start = 1'b0; rst = 1'b0; i_ready = 1'b1;
  endtask

  typedef struct {
    logic start, valid, ready, rst;
    logic e_ready, e_ce, e_srst, e_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                start valid ready rst | ready ce srst busy
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // IDLE, start
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};  // CLEAR
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // accept (0,0)
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // no valid
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // start ignored
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // sync rst
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // back in IDLE

    global_rst_n = 1'b0; rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    global_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      i_start = tbl[i].start; i_valid = tbl[i].valid;
      i_ready = tbl[i].ready; rst = tbl[i].rst;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_ce", i), o_ce, tbl[i].e_ce);
      chk($sformatf("tbl%0d_srst", i), o_self_rst, tbl[i].e_srst);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_wv", i), o_win_valid, 0);
      chk($sformatf("tbl%0d_done", i), o_done, 0);
    end
    @(posedge clk); #1;
    i_start = 1'b0; i_valid = 1'b0; rst = 1'b0;

    // Asynchronous reset in the middle of a map with a window pending.
    @(posedge clk); #1; i_start = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1; i_start = 1'b0; i_valid = 1'b1;
    repeat (22) @(posedge clk);
    @(negedge clk);
    chk("async_pre_wv", o_win_valid, 1);
    chk("async_pre_busy", o_busy, 1);
    #2 global_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1;
    i_valid = 1'b0;
    global_rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("async_release");

    run_map(0, 0, -1, "cont");
    run_map(0, 1, -1, "stall");
    run_map(1, 0, -1, "toggle");
    run_map(0, 0, 20, "rst20");
    run_map(0, 0, -1, "restart");
    for (int n = 0; n < 4; n++) run_map(2, 2, -1, $sformatf("rand%0d", n));
    run_map(2, 2, int'($urandom_range(1, TOTAL_PIX - 1)), "rand_rst");
    run_map(2, 2, -1, "rand_after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
